// File: rtl/sd_arb_pkg.sv
// Shared constants for the SD-card register port arbiter and the SD wrapper.
package sd_arb_pkg;

  localparam int SD_REG_ADDR_W = 6;
  localparam int SD_REG_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_OWN_B     = 2'd1,
    ST_WAIT_DROP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sd_arb_watchdog.sv
// Idle-cycle watchdog for the B-side owner; flags expiry on the cycle whose
// increment would reach TIMEOUT_CYCLES.
module sd_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry fires on the idle cycle that completes TIMEOUT_CYCLES idle cycles.
  assign expired_o = en_i && !clr_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sd_bus_arbiter.sv
// Shares the SD SPI master register port between the CPU (never stalled) and
// the log-writer engine B, which takes exclusive ownership for block transfers.
module sd_bus_arbiter
  import sd_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int DROP_CNT_W     = 8
) (
  input  logic                     clk_peri,
  input  logic                     reset,
  input  logic                     cpu_sel,
  input  logic                     cpu_we,
  input  logic [SD_REG_ADDR_W-1:0] cpu_addr,
  input  logic [SD_REG_DATA_W-1:0] cpu_wdata,
  output logic [SD_REG_DATA_W-1:0] cpu_rdata,
  input  logic                     cpu_lock,
  output logic                     cpu_busy,
  input  logic                     cpu_drop_clr,
  output logic [DROP_CNT_W-1:0]    drop_cnt,
  input  logic                     b_req,
  output logic                     b_gnt,
  input  logic                     b_sel,
  input  logic                     b_we,
  input  logic [SD_REG_ADDR_W-1:0] b_addr,
  input  logic [SD_REG_DATA_W-1:0] b_wdata,
  output logic [SD_REG_DATA_W-1:0] b_rdata,
  output logic                     b_timeout,
  output logic                     m_strobe,
  output logic                     m_we,
  output logic [SD_REG_ADDR_W-1:0] m_addr,
  output logic [SD_REG_DATA_W-1:0] m_wdata,
  input  logic [SD_REG_DATA_W-1:0] m_rdata
);

  arb_state_e            state_q, state_d;
  logic                  b_timeout_q, b_timeout_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  own_b;
  logic                  wd_expired;

  assign own_b = (state_q == ST_OWN_B);

  sd_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_peri),
    .rst_n_i  (reset),
    .clr_i    (!own_b || b_sel),
    .en_i     (own_b),
    .expired_o(wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    b_timeout_d = 1'b0;
    case (state_q)
      // Grant is deferred while a CPU access is in flight.
      ST_IDLE: begin
        if (b_req && !cpu_lock && !cpu_sel) state_d = ST_OWN_B;
      end
      ST_OWN_B: begin
        if (!b_req) begin
          state_d = ST_IDLE;
        end else if (wd_expired) begin
          state_d     = ST_WAIT_DROP;
          b_timeout_d = 1'b1;
        end
      end
      ST_WAIT_DROP: begin
        if (!b_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (cpu_drop_clr) begin
      drop_d = '0;
    end else if (own_b && cpu_sel && !(&drop_q)) begin
      drop_d = drop_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_peri or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      b_timeout_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      b_timeout_q <= b_timeout_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    m_strobe  = cpu_sel;
    m_we      = cpu_we;
    m_addr    = cpu_addr;
    m_wdata   = cpu_wdata;
    cpu_rdata = m_rdata;
    b_rdata   = '0;
    if (own_b) begin
      m_strobe  = b_sel && b_gnt;
      m_we      = b_we && b_gnt;
      m_addr    = b_addr;
      m_wdata   = b_wdata;
      cpu_rdata = '0;
      b_rdata   = m_rdata;
    end
  end

  assign b_gnt     = own_b;
  assign cpu_busy  = own_b;
  assign b_timeout = b_timeout_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_sd_bus_arbiter.sv
// Directed bench for sd_bus_arbiter with an ownership model checked every cycle.
module tb_sd_bus_arbiter;

  localparam int TMO = 16;
  localparam int DW  = 8;

  logic       clk_peri = 1'b0;
  logic       reset;
  logic       cpu_sel, cpu_we, cpu_lock, cpu_drop_clr;
  logic [5:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       cpu_busy;
  logic [DW-1:0] drop_cnt;
  logic       b_req, b_gnt, b_sel, b_we, b_timeout;
  logic [5:0] b_addr;
  logic [7:0] b_wdata, b_rdata;
  logic       m_strobe, m_we;
  logic [5:0] m_addr;
  logic [7:0] m_wdata, m_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  sd_bus_arbiter #(.TIMEOUT_CYCLES(TMO), .DROP_CNT_W(DW)) dut (
    .clk_peri(clk_peri), .reset(reset),
    .cpu_sel(cpu_sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_lock(cpu_lock), .cpu_busy(cpu_busy),
    .cpu_drop_clr(cpu_drop_clr), .drop_cnt(drop_cnt),
    .b_req(b_req), .b_gnt(b_gnt), .b_sel(b_sel), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rdata(b_rdata), .b_timeout(b_timeout),
    .m_strobe(m_strobe), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  always #5 clk_peri = ~clk_peri;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ownership model: who holds the port, how long B has sat idle, drops seen.
  typedef enum {CPU_OWNS, B_OWNS, B_REVOKED} owner_t;
  owner_t mdl_owner;
  int     mdl_idle;
  int     mdl_drop;
  bit     mdl_pulse;

  always @(posedge clk_peri or negedge reset) begin
    if (!reset) begin
      mdl_owner = CPU_OWNS;
      mdl_idle  = 0;
      mdl_drop  = 0;
      mdl_pulse = 0;
    end else begin
      mdl_pulse = 0;
      if (cpu_drop_clr) mdl_drop = 0;
      else if (mdl_owner == B_OWNS && cpu_sel && mdl_drop < 255) mdl_drop = mdl_drop + 1;
      case (mdl_owner)
        CPU_OWNS: if (b_req && !cpu_lock && !cpu_sel) begin
          mdl_owner = B_OWNS;
          mdl_idle  = 0;
        end
        B_OWNS: begin
          if (!b_req) mdl_owner = CPU_OWNS;
          else begin
            mdl_idle = b_sel ? 0 : mdl_idle + 1;
            if (mdl_idle >= TMO) begin
              mdl_owner = B_REVOKED;
              mdl_pulse = 1;
            end
          end
        end
        default: if (!b_req) mdl_owner = CPU_OWNS;
      endcase
    end
  end

  always @(negedge clk_peri) begin
    if (mdl_owner == B_OWNS) begin
      chk("m_strobe", m_strobe, b_sel);
      chk("m_we", m_we, b_we);
      chk("m_addr", m_addr, b_addr);
      chk("m_wdata", m_wdata, b_wdata);
      chk("b_rdata", b_rdata, m_rdata);
      chk("cpu_rdata", cpu_rdata, 0);
    end else begin
      chk("m_strobe", m_strobe, cpu_sel);
      chk("m_we", m_we, cpu_we);
      chk("m_addr", m_addr, cpu_addr);
      chk("m_wdata", m_wdata, cpu_wdata);
      chk("b_rdata", b_rdata, 0);
      chk("cpu_rdata", cpu_rdata, m_rdata);
    end
    chk("b_gnt", b_gnt, mdl_owner == B_OWNS);
    chk("cpu_busy", cpu_busy, mdl_owner == B_OWNS);
    chk("b_timeout", b_timeout, mdl_pulse);
    chk("drop_cnt", drop_cnt, mdl_drop);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_peri);
    #1;
  endtask

  initial begin
    int pulses, pulse_at, grants;
    reset = 1'b0;
    cpu_sel = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_lock = 0; cpu_drop_clr = 0;
    b_req = 0; b_sel = 0; b_we = 0; b_addr = 0; b_wdata = 0; m_rdata = 8'h3C;
    step(2);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_busy", cpu_busy, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_timeout", b_timeout, 0);
    reset = 1'b1;
    step(1);

    // Request during a CPU access: CPU write passes, grant waits one quiet cycle.
    b_req = 1; cpu_sel = 1; cpu_we = 1; cpu_addr = 6'h02; cpu_wdata = 8'h5A;
    #1;
    chk("defer_m_strobe", m_strobe, 1);
    chk("defer_m_addr", m_addr, 6'h02);
    chk("defer_m_wdata", m_wdata, 8'h5A);
    step(1);
    chk("defer_no_gnt", b_gnt, 0);
    cpu_sel = 0; cpu_we = 0;
    step(1);
    chk("defer_gnt", b_gnt, 1);

    // CPU accesses during B ownership are dropped and counted.
    m_rdata = 8'h77;
    for (int i = 0; i < 4; i++) begin
      cpu_sel = 1; cpu_we = (i < 3); cpu_addr = 6'(i + 8); cpu_wdata = 8'(8'hA0 + i);
      #1;
      chk("drop_no_strobe", m_strobe, 0);
      if (i == 3) chk("drop_read_zero", cpu_rdata, 8'h00);
      step(1);
    end
    cpu_sel = 0; cpu_we = 0;
    chk("drop_cnt_4", drop_cnt, 4);
    b_sel = 1; b_we = 1; b_addr = 6'h05; b_wdata = 8'h11;
    #1;
    chk("b_strobe", m_strobe, 1);
    chk("b_addr", m_addr, 6'h05);
    chk("b_rdata", b_rdata, 8'h77);
    cpu_drop_clr = 1;
    step(1);
    cpu_drop_clr = 0;
    chk("drop_clr", drop_cnt, 0);

    // Release with a final B access in the same cycle.
    b_req = 0; b_addr = 6'h09;
    #1;
    chk("rel_strobe", m_strobe, 1);
    chk("rel_addr", m_addr, 6'h09);
    step(1);
    chk("rel_gnt", b_gnt, 0);
    #1;
    chk("ungated_b_sel", m_strobe, 0);
    b_sel = 0; b_we = 0;
    step(1);

    // Watchdog: idle owner revoked 16 cycles after grant.
    b_req = 1;
    step(1);
    chk("tmo_gnt", b_gnt, 1);
    pulses = 0; pulse_at = 0;
    for (int k = 1; k <= 18; k++) begin
      step(1);
      if (b_timeout) begin
        pulses++;
        pulse_at = k;
      end
    end
    chk("tmo_pulses", pulses, 1);
    chk("tmo_cycle", pulse_at, 16);
    chk("tmo_gnt_low", b_gnt, 0);
    b_sel = 1; b_addr = 6'h21;
    step(3);
    chk("wait_drop_gnt", b_gnt, 0);
    chk("wait_drop_strobe", m_strobe, 0);
    b_sel = 0;
    b_req = 0;
    step(1);
    b_req = 1;
    step(1);
    chk("regrant", b_gnt, 1);
    b_req = 0;
    step(1);

    // cpu_lock blocks new grants only.
    cpu_lock = 1; b_req = 1; grants = 0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      if (b_gnt) grants++;
    end
    chk("lock_no_grant", grants, 0);
    cpu_lock = 0;
    step(1);
    chk("unlock_gnt", b_gnt, 1);
    cpu_lock = 1;
    step(3);
    chk("lock_no_preempt", b_gnt, 1);

    // Saturation of the drop counter.
    b_sel = 1; b_we = 0; cpu_sel = 1; cpu_we = 1;
    step(254);
    chk("drop_fe", drop_cnt, 8'hFE);
    step(1);
    chk("drop_ff", drop_cnt, 8'hFF);
    step(2);
    chk("drop_sat", drop_cnt, 8'hFF);

    // Asynchronous reset in the middle of B ownership.
    b_sel = 0; cpu_addr = 6'h03; cpu_wdata = 8'hA5;
    #1 reset = 0;
    #1;
    chk("arst_gnt", b_gnt, 0);
    chk("arst_busy", cpu_busy, 0);
    chk("arst_drop", drop_cnt, 0);
    step(1);
    chk("arst_m_strobe", m_strobe, 1);
    chk("arst_m_addr", m_addr, 6'h03);
    chk("arst_m_wdata", m_wdata, 8'hA5);
    reset = 1; cpu_sel = 0; cpu_we = 0; b_req = 0; cpu_lock = 0;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
